afe_rx_chan_decoder: RTL
========================

AFE_RX_CHAN_DECODER -- requirements
Module: afe_rx_chan_decoder

Interface
REQ-001 Parameter AFE_IDX, default 0, selects this instance's entries in every afe_parameters_pkg array.
REQ-002 Parameter FIFO_DEPTH, default 4, sets the output FIFO depth in words, power of two, >=2.
REQ-003 Derived widths: DW=AFE_RX_DATA_W[AFE_IDX]; NL2=AFE_RX_NUM_L2CHS[AFE_IDX]; CW=AFE_RX_CHID_WIDTH[AFE_IDX]; SW=max(1,AFE_RX_SUBCHID_WIDTH[AFE_IDX]); FW=max(1,AFE_RX_FLAG_WIDTH[AFE_IDX]); LW=max(1,$clog2(NL2)).
REQ-004 Clock and reset are fixed: one clock; reset is asynchronous and active-high.
REQ-005 clk_i  in  1  sole clock.
REQ-006 rst_i  in  1  asynchronous active-high reset.
REQ-007 cfg_en_i  in  1  decoder enable; when 0, input words are discarded uncounted.
REQ-008 cfg_ch_en_i  in  NL2  per-L2-channel enable.
REQ-009 cfg_mask_mode_i  in  2  output format: 0 payload, 1 payload+flags, 2 raw, 3 sign-extended payload.
REQ-010 cfg_l2ch_chid_i  in  NL2*CW  AFE channel id per L2 channel; used for type 2 only.
REQ-011 cfg_clr_i  in  1  single-cycle pulse; clears sticky flags and the drop counter.
REQ-012 afe_valid_i / afe_ready_o / afe_data_i  in/out/in  1/1/DW  upstream word stream from the AFE receiver.
REQ-013 out_valid_o / out_ready_i  out/in  1/1  downstream handshake toward the L2 channel/uDMA stage.
REQ-014 out_data_o  out  32  formatted word.
REQ-015 out_l2ch_o  out  LW  target L2 channel.
REQ-016 out_subch_o  out  SW  sub-channel id (type 1 only), else 0.
REQ-017 flags_o  out  NL2*FW  sticky per-L2-channel flags.
REQ-018 drop_cnt_o  out  16  saturating overflow-drop count.
REQ-019 overflow_o  out  1  one-cycle pulse per dropped word.

Function
REQ-020 afe_ready_o SHALL be 0 while rst_i=1 and constant 1 otherwise; the block never back-pressures the AFE.
REQ-021 Decoding: chid=afe_data_i[CHID_LSB+:CW]; subch=afe_data_i[SUBCHID_LSB+:SW]; flags=afe_data_i[FLAG_LSB+:FW].
REQ-022 Type 0 and type 1: l2ch=chid; if chid>=NL2, the word is discarded uncounted.
REQ-023 Type 2: l2ch is the lowest index i with cfg_ch_en_i[i]=1 and cfg_l2ch_chid_i[i]=chid; if no index matches, the word is discarded uncounted.
REQ-024 A word mapped to a channel with cfg_ch_en_i=0 is discarded uncounted.
REQ-025 Formatting: mode 0 gives data&AFE_RX_MASK_PL; mode 1 gives data&AFE_RX_MASK_FL; mode 2 gives data zero-extended to 32; mode 3 gives the payload sign-extended from bit AFE_PL_DATA_W-1.
REQ-026 A valid mapped word is written to the FIFO in its accept cycle N and is visible on out_* at N+1 when the FIFO was empty.
REQ-027 out_* SHALL hold stable while out_valid_o=1 and out_ready_i=0.
REQ-028 Push to a full FIFO with no pop drops the word, increments drop_cnt_o (saturating at 0xFFFF) and pulses overflow_o at N+1.
REQ-029 Push and pop in the same cycle while full: the push is accepted, occupancy is unchanged and no drop occurs.
REQ-030 Flags capture applies when AFE_FLAG_MASK[AFE_IDX]=1 and FLAG_WIDTH>0: flags_o[l2ch] |= flags for every mapped word, including overflow drops.
REQ-031 cfg_clr_i clears flags_o and drop_cnt_o; a capture or increment in the same cycle wins over the clear.
REQ-032 Configuration changes take effect on the next accepted word; words already in the FIFO are unaffected.

Reset
REQ-033 Asserting rst_i SHALL asynchronously empty the FIFO and force out_valid_o=0, out_data_o=0, out_l2ch_o=0, out_subch_o=0, flags_o=0, drop_cnt_o=0, overflow_o=0, afe_ready_o=0, including mid-transfer.

Structure
REQ-034 The mask-mode enum afe_mask_mode_e SHALL be added to afe_parameters_pkg; all per-AFE constants come from that package.
REQ-035 The FIFO SHALL be the sub-module afe_rx_dec_fifo, holding {data, l2ch, subch}.

Verification
REQ-036 AFE_IDX=0 (type 2), cfg_l2ch_chid={9,7,5,5}, all channels enabled, mode 0, input 0x16800001 -> out_data 0x00800001, out_l2ch 0, flags_o[0]=1.
REQ-037 Same input in mode 3 -> 0xFF800001; in mode 1 -> 0x02800001.
REQ-038 AFE_IDX=1 (type 1), input 0x3B00ABCD, mode 0 -> out_l2ch 3, out_subch 2, out_data 0x0000ABCD.
REQ-039 AFE_IDX=2 (type 0), input with chid 13 -> no output and drop_cnt_o unchanged.
REQ-040 FIFO_DEPTH=4, out_ready_i=0, six back-to-back words -> 4 stored, drop_cnt_o=2, two overflow_o pulses; then out_ready_i=1 -> the 4 words drain in order.
REQ-041 rst_i pulse while 3 words are queued -> out_valid_o=0 immediately; after release, a new word appears 1 cycle after accept.

Source files
------------

// File: rtl/afe_parameters_pkg.sv
// Per-AFE receiver constants and the output mask-mode encoding.
package afe_parameters_pkg;

  localparam int unsigned AFE_NUM = 3;

  // AFE 0: type 2 (id lookup), AFE 1: type 1 (id + sub-id), AFE 2: type 0 (plain id).
  localparam int unsigned AFE_RX_TYPE          [AFE_NUM] = '{2, 1, 0};
  localparam int unsigned AFE_RX_DATA_W        [AFE_NUM] = '{32, 32, 16};
  localparam int unsigned AFE_RX_NUM_L2CHS     [AFE_NUM] = '{4, 4, 8};
  localparam int unsigned AFE_RX_CHID_WIDTH    [AFE_NUM] = '{4, 2, 4};
  localparam int unsigned AFE_RX_CHID_LSB      [AFE_NUM] = '{26, 28, 12};
  localparam int unsigned AFE_RX_SUBCHID_WIDTH [AFE_NUM] = '{0, 2, 0};
  localparam int unsigned AFE_RX_SUBCHID_LSB   [AFE_NUM] = '{0, 26, 0};
  localparam int unsigned AFE_RX_FLAG_WIDTH    [AFE_NUM] = '{1, 2, 0};
  localparam int unsigned AFE_RX_FLAG_LSB      [AFE_NUM] = '{25, 24, 0};
  localparam int unsigned AFE_FLAG_MASK        [AFE_NUM] = '{1, 1, 0};
  localparam int unsigned AFE_PL_DATA_W        [AFE_NUM] = '{24, 16, 12};

  localparam logic [31:0] AFE_RX_MASK_PL [AFE_NUM] = '{32'h00FF_FFFF, 32'h0000_FFFF,
                                                       32'h0000_0FFF};
  localparam logic [31:0] AFE_RX_MASK_FL [AFE_NUM] = '{32'h02FF_FFFF, 32'h0300_FFFF,
                                                       32'h0000_0FFF};

  typedef enum logic [1:0] {
    AfeMaskPl   = 2'd0,
    AfeMaskFl   = 2'd1,
    AfeMaskRaw  = 2'd2,
    AfeMaskSext = 2'd3
  } afe_mask_mode_e;

  // Zero-width fields still need a 1-bit port.
  function automatic int unsigned max1(input int unsigned v);
    return (v > 1) ? v : 1;
  endfunction

endpackage

// File: rtl/afe_rx_dec_fifo.sv
// Small synchronous FIFO; head word is presented combinationally from storage.
module afe_rx_dec_fifo #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic             valid_o,
  output logic             full_o,
  output logic [Width-1:0] rdata_o
);

  localparam int unsigned AW = $clog2(Depth);

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] mem_d [Depth];
  logic             wr_en, rd_en;

  assign valid_o = (cnt_q != '0);
  assign full_o  = (cnt_q == (AW+1)'(Depth));
  assign rdata_o = mem_q[rd_ptr_q];
  // A pop in the same cycle frees the slot, so a push to a full FIFO still lands.
  assign wr_en   = push_i & (~full_o | pop_i);
  assign rd_en   = pop_i & valid_o;

  // Pointer, occupancy and storage next-state.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    mem_d    = mem_q;
    if (wr_en) begin
      mem_d[wr_ptr_q] = wdata_i;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (rd_en) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({wr_en, rd_en})
      2'b10:   cnt_d = cnt_q + (AW+1)'(1);
      2'b01:   cnt_d = cnt_q - (AW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Control state; reset empties the FIFO immediately.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage needs no reset; readers only see it while valid_o is high.
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/afe_rx_chan_decoder.sv
// Decodes AFE receiver words into L2-channel targets, formats them and queues them.
module afe_rx_chan_decoder
  import afe_parameters_pkg::*;
#(
  parameter int unsigned AFE_IDX    = 0,
  parameter int unsigned FIFO_DEPTH = 4,
  localparam int unsigned DW  = AFE_RX_DATA_W[AFE_IDX],
  localparam int unsigned NL2 = AFE_RX_NUM_L2CHS[AFE_IDX],
  localparam int unsigned CW  = AFE_RX_CHID_WIDTH[AFE_IDX],
  localparam int unsigned SW  = max1(AFE_RX_SUBCHID_WIDTH[AFE_IDX]),
  localparam int unsigned FW  = max1(AFE_RX_FLAG_WIDTH[AFE_IDX]),
  localparam int unsigned LW  = max1($clog2(NL2))
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cfg_en_i,
  input  logic [NL2-1:0]    cfg_ch_en_i,
  input  logic [1:0]        cfg_mask_mode_i,
  input  logic [NL2*CW-1:0] cfg_l2ch_chid_i,
  input  logic              cfg_clr_i,
  input  logic              afe_valid_i,
  output logic              afe_ready_o,
  input  logic [DW-1:0]     afe_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [31:0]       out_data_o,
  output logic [LW-1:0]     out_l2ch_o,
  output logic [SW-1:0]     out_subch_o,
  output logic [NL2*FW-1:0] flags_o,
  output logic [15:0]       drop_cnt_o,
  output logic              overflow_o
);

  localparam int unsigned RX_TYPE     = AFE_RX_TYPE[AFE_IDX];
  localparam int unsigned CHID_LSB    = AFE_RX_CHID_LSB[AFE_IDX];
  localparam int unsigned SUBCHID_LSB = AFE_RX_SUBCHID_LSB[AFE_IDX];
  localparam int unsigned FLAG_LSB    = AFE_RX_FLAG_LSB[AFE_IDX];
  localparam int unsigned PLW         = AFE_PL_DATA_W[AFE_IDX];
  localparam logic [31:0] MASK_PL     = AFE_RX_MASK_PL[AFE_IDX];
  localparam logic [31:0] MASK_FL     = AFE_RX_MASK_FL[AFE_IDX];
  localparam logic [31:0] PL_LO_MASK  = 32'((64'd1 << PLW) - 64'd1);
  localparam bit          CAPTURE     = (AFE_FLAG_MASK[AFE_IDX] == 1) &&
                                        (AFE_RX_FLAG_WIDTH[AFE_IDX] > 0);
  localparam int unsigned EW          = 32 + LW + SW;

  logic [CW-1:0]     chid;
  logic [SW-1:0]     subch;
  logic [FW-1:0]     flags;
  logic [LW-1:0]     l2ch;
  logic              hit;
  logic [31:0]       data32, pl_lo, fmt;
  logic              push_req, pop, drop;
  logic              fifo_valid, fifo_full;
  logic [EW-1:0]     fifo_rdata;
  logic [NL2*FW-1:0] flags_q, flags_d;
  logic [15:0]       drop_cnt_q, drop_cnt_d;
  logic              overflow_q, overflow_d;

  assign afe_ready_o = ~rst_i;

  // Field extraction and channel mapping.
  always_comb begin
    chid  = afe_data_i[CHID_LSB +: CW];
    subch = (RX_TYPE == 1) ? afe_data_i[SUBCHID_LSB +: SW] : '0;
    flags = afe_data_i[FLAG_LSB +: FW];
    hit   = 1'b0;
    l2ch  = '0;
    if (RX_TYPE == 2) begin
      // Descending scan so the lowest matching index is the one left standing.
      for (int i = NL2 - 1; i >= 0; i--) begin
        if (cfg_ch_en_i[i] && (cfg_l2ch_chid_i[i*CW +: CW] == chid)) begin
          hit  = 1'b1;
          l2ch = LW'(i);
        end
      end
    end else if (32'(chid) < NL2) begin
      l2ch = LW'(chid);
      hit  = cfg_ch_en_i[l2ch];
    end
  end

  // Output word formatting.
  always_comb begin
    data32 = 32'(afe_data_i);
    pl_lo  = data32 & MASK_PL;
    unique case (afe_mask_mode_e'(cfg_mask_mode_i))
      AfeMaskPl:   fmt = pl_lo;
      AfeMaskFl:   fmt = data32 & MASK_FL;
      AfeMaskRaw:  fmt = data32;
      AfeMaskSext: fmt = pl_lo[PLW-1] ? (pl_lo | ~PL_LO_MASK) : pl_lo;
      default:     fmt = pl_lo;
    endcase
  end

  assign push_req = afe_valid_i & afe_ready_o & cfg_en_i & hit;
  assign pop      = fifo_valid & out_ready_i;
  assign drop     = push_req & fifo_full & ~pop;

  afe_rx_dec_fifo #(
    .Depth (FIFO_DEPTH),
    .Width (EW)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push_req),
    .wdata_i ({fmt, l2ch, subch}),
    .pop_i   (out_ready_i),
    .valid_o (fifo_valid),
    .full_o  (fifo_full),
    .rdata_o (fifo_rdata)
  );

  // Sticky flags and drop counter; a same-cycle capture or increment overrides the clear.
  always_comb begin
    flags_d    = flags_q;
    drop_cnt_d = drop_cnt_q;
    overflow_d = drop;
    if (cfg_clr_i && !(CAPTURE && push_req)) begin
      flags_d = '0;
    end
    if (cfg_clr_i && !drop) begin
      drop_cnt_d = '0;
    end
    if (CAPTURE && push_req) begin
      flags_d[l2ch*FW +: FW] = flags_q[l2ch*FW +: FW] | flags;
    end
    if (drop && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_d = drop_cnt_q + 16'd1;
    end
  end

  // Status registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      flags_q    <= '0;
      drop_cnt_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      flags_q    <= flags_d;
      drop_cnt_q <= drop_cnt_d;
      overflow_q <= overflow_d;
    end
  end

  // Outputs read zero whenever nothing is queued.
  always_comb begin
    out_valid_o = fifo_valid;
    out_data_o  = fifo_valid ? fifo_rdata[EW-1 -: 32] : '0;
    out_l2ch_o  = fifo_valid ? fifo_rdata[SW +: LW] : '0;
    out_subch_o = fifo_valid ? fifo_rdata[SW-1:0] : '0;
  end

  assign flags_o    = flags_q;
  assign drop_cnt_o = drop_cnt_q;
  assign overflow_o = overflow_q;

endmodule
